// File: rtl/mem_sweep_checker.sv
// mem_sweep_checker: fills a write-every-cycle BRAM with an address
// derived pattern (optional) and reads it back, counting bad words.
module mem_sweep_checker #(
  parameter int unsigned WID_MEM   = 128,
  parameter int unsigned DEPTH_MEM = 128,
  parameter int unsigned PARK_ADDR = DEPTH_MEM - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               do_fill,
  input  logic [31:0]        seed,
  output logic [31:0]        raddr,
  output logic [31:0]        waddr,
  output logic [WID_MEM-1:0] din,
  input  logic [WID_MEM-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [31:0]        err_count,
  output logic [31:0]        first_err_addr
);

  localparam logic [31:0] PARK  = 32'(PARK_ADDR);
  localparam logic [31:0] FIRST = (PARK_ADDR == 0) ? 32'd1 : 32'd0;
  localparam logic [31:0] NWORD = 32'(DEPTH_MEM - 1);
  localparam logic [31:0] NONE  = '1;

  typedef enum logic [1:0] {IDLE, FILL, VERIFY, DRAIN} state_t;

  state_t state, state_d;

  logic [31:0]        cur, cur_d;
  logic [31:0]        cnt, cnt_d;
  logic [31:0]        nxt, seed_q;
  logic [31:0]        raddr_d, waddr_d;
  logic [WID_MEM-1:0] din_d;
  logic [31:0]        chk_a, err_d, first_d;
  logic               go, last, rv, chk_v, mis;

  function automatic logic [WID_MEM-1:0] pat(
    input logic [31:0] s,
    input logic [31:0] a
  );
    return {(WID_MEM/32){s ^ a ^ {a[15:0], a[31:16]}}};
  endfunction

  assign go   = (state == IDLE) && start;
  assign last = (cnt == NWORD);
  assign busy = (state != IDLE);

  // the park word is skipped by the sweep
  always_comb begin
    nxt = cur + 32'd1;
    if (nxt == PARK) nxt = cur + 32'd2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = do_fill ? FILL : VERIFY;
      FILL:    if (last) state_d = VERIFY;
      VERIFY:  if (last) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_d   = cur;
    cnt_d   = cnt;
    raddr_d = '0;
    waddr_d = PARK;
    din_d   = '0;
    unique case (state)
      IDLE: if (start) begin
        cur_d   = FIRST;
        cnt_d   = 32'd1;
        raddr_d = FIRST;
        if (do_fill) begin
          waddr_d = FIRST;
          din_d   = pat(seed, FIRST);
        end
      end
      FILL: if (last) begin
        cur_d   = FIRST;
        cnt_d   = 32'd1;
        raddr_d = FIRST;
      end else begin
        cur_d   = nxt;
        cnt_d   = cnt + 32'd1;
        raddr_d = nxt;
        waddr_d = nxt;
        din_d   = pat(seed_q, nxt);
      end
      VERIFY: if (!last) begin
        cur_d   = nxt;
        cnt_d   = cnt + 32'd1;
        raddr_d = nxt;
      end
      default: ;
    endcase
  end

  // chk_* trail raddr by one cycle, matching the registered dout
  always_comb begin
    mis     = chk_v && (dout != pat(seed_q, chk_a));
    err_d   = err_count;
    first_d = first_err_addr;
    if (go) begin
      err_d   = '0;
      first_d = NONE;
    end else if (mis) begin
      if (err_count != NONE)      err_d   = err_count + 32'd1;
      if (first_err_addr == NONE) first_d = chk_a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur            <= '0;
      cnt            <= '0;
      seed_q         <= '0;
      raddr          <= '0;
      waddr          <= PARK;
      din            <= '0;
      rv             <= 1'b0;
      chk_v          <= 1'b0;
      chk_a          <= '0;
      err_count      <= '0;
      first_err_addr <= NONE;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      cur            <= cur_d;
      cnt            <= cnt_d;
      raddr          <= raddr_d;
      waddr          <= waddr_d;
      din            <= din_d;
      rv             <= (state_d == VERIFY);
      chk_v          <= rv;
      chk_a          <= cur;
      err_count      <= err_d;
      first_err_addr <= first_d;
      if (go) seed_q <= seed;
      if (go) begin
        done <= 1'b0;
        pass <= 1'b0;
      end else if (state == DRAIN) begin
        done <= 1'b1;
        pass <= (err_d == '0);
      end
    end
  end

endmodule

// File: doc/mem_sweep_checker.md
Name: mem_sweep_checker

Overview:
- Upstream driver for the single-clock BRAM `memory` block. It owns all of that block's inputs: `raddr`, `waddr`, `din`.
- It consumes the block's `dout`.
- It fills the memory with a deterministic address-derived pattern, or skips the fill. It then reads every word back and counts mismatches.
- Main use: checking RAM contents after a bitstream-driven memory re-initialisation.
- The memory has no write enable and writes `ram[waddr] <= din` on every edge. This block therefore reserves one scratch word (`PARK_ADDR`) to absorb writes whenever it is not filling.

Parameters:
- `WID_MEM`, 128, memory word width in bits. Must be a multiple of 32.
- `DEPTH_MEM`, 128, memory depth in words. Range 2..2^31.
- `PARK_ADDR`, `DEPTH_MEM`-1, scratch address written whenever the block is not filling. Excluded from fill and verify.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low. 0 = reset asserted.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `do_fill`  in  1  sampled with `start`. 1 = FILL then VERIFY; 0 = VERIFY only, checking existing contents.
- `seed`  in  32  pattern seed, sampled with `start`.
- `raddr`  out  32  to `memory.raddr`.
- `waddr`  out  32  to `memory.waddr`.
- `din`  out  `WID_MEM`  to `memory.din`.
- `dout`  in  `WID_MEM`  from `memory.dout`. Registered; valid 1 cycle after `raddr`.
- `busy`  out  1  high in FILL, VERIFY and DRAIN.
- `done`  out  1  sticky; set on the cycle DRAIN is left; cleared on accepted `start`.
- `pass`  out  1  valid when `done`=1; 1 iff `err_count`==0.
- `err_count`  out  32  number of mismatching words; saturates at 0xFFFFFFFF.
- `first_err_addr`  out  32  address of the first mismatch; 0xFFFFFFFF if none.

Behaviour:
- Pattern:
  - Word count N = `DEPTH_MEM`-1.
  - Swept addresses are 0..`DEPTH_MEM`-1 excluding `PARK_ADDR`, ascending.
  - Expected word for address a: the 32-bit value (`seed_q` XOR a XOR {a[15:0],a[31:16]}) replicated `WID_MEM`/32 times.
  - `seed_q` is the registered seed.
- Reset (async assert, sync release). All outputs are reset values:
  - `raddr`=0, `waddr`=`PARK_ADDR`, `din`=0.
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0xFFFFFFFF.
  - state=IDLE.
- Reset mid-operation aborts immediately. Memory contents are then undefined; no resume.
- States: IDLE, FILL, VERIFY, DRAIN.
- IDLE:
  - `raddr`=0, `waddr`=`PARK_ADDR`, `din`=0.
  - On `start`=1: latch `seed_q` and `fill_q`; clear `done`, `err_count` and `first_err_addr`.
  - Go to FILL if `do_fill`=1, else VERIFY.
  - `busy` goes high the next cycle.
- FILL:
  - One word per cycle. `waddr`=cur, `din`=pattern(cur), `raddr`=cur.
  - Exactly N cycles. After the last word, go to VERIFY with cur reset to the first swept address.
- VERIFY:
  - `raddr`=cur, one per cycle, N cycles. `waddr`=`PARK_ADDR`, `din`=0.
  - A 1-cycle delayed copy of (cur, valid) is kept.
  - On each cycle where the delayed valid is set, compare `dout` with pattern(delayed cur).
  - On mismatch: increment `err_count` (saturating). Load `first_err_addr` if it is still 0xFFFFFFFF.
- DRAIN:
  - One cycle to compare the last word.
  - Then IDLE, with `busy`=0, `done`=1, and `pass` = (`err_count`==0 including this final compare).
- Latency from `start` to `done`:
  - fill+verify = 2N+2 cycles.
  - verify-only = N+2 cycles.
- `start` while `busy` is ignored. `start` in the same cycle `done` sets is ignored; that cycle is still DRAIN.
- Outputs `raddr`, `waddr` and `din` are registered. The block never drives an out-of-range address.
- The contents of `PARK_ADDR` are never checked and are clobbered continuously.

Test Plan:
- Defaults, memory preloaded with zeros; `start`=1, `do_fill`=1, `seed`=0x0 -> 127 fill writes to addresses 0..126, then 127 reads. `done` at cycle 256 after `start`; `pass`=1, `err_count`=0, `first_err_addr`=0xFFFFFFFF.
- Verify-only, `seed`=0x0, on a memory still holding the previous fill -> `done` after 129 cycles, `pass`=1.
- Verify-only, `seed`=0x0, after forcing `ram[5]` and `ram[90]` to 0 (address 0's pattern word is 0, so it is not a detectable corruption) -> `err_count`=2, `first_err_addr`=5, `pass`=0.
- Fill with `seed`=0xA5A5A5A5, then verify-only with `seed`=0x0 -> `err_count`=127, `first_err_addr`=0.
- `reset` low at fill cycle 40, released, then full run with `seed`=0x1 -> the aborted run leaves `done`=0 and `err_count`=0. The new run reports `pass`=1.
- `start` pulsed again mid-VERIFY -> ignored; `done` timing unchanged. `waddr`==127 on every non-FILL cycle.
